div_clk_monitor: RTL

- Downstream consumer of the mod-N divider output.
- Samples the divided clock as data in the system clock domain and produces single-cycle rise/fall strobes.
- Measures the period and high time of the divided clock in system-clock cycles.
- Compares the measured period against an expected value, reports lock, and latches sticky period and timeout errors for status logic.

---
 rtl/div_clk_monitor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/div_clk_monitor.sv
// Monitors a divided clock sampled as data: edge strobes, period/high-time
// measurement, lock detection against an expected period, sticky error flags.
module div_clk_monitor #(
  parameter int MAX_PERIOD = 255,
  parameter int LOCK_CNT   = 4,
  localparam int CW  = $clog2(MAX_PERIOD + 1),
  localparam int LCW = $clog2(LOCK_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_in,
  input  logic          en,
  input  logic [CW-1:0] exp_period,
  input  logic          clr_err,
  output logic          rise_pulse,
  output logic          fall_pulse,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          err_period,
  output logic          err_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CW-1:0]  MAX_CNT   = CW'(MAX_PERIOD);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CNT - 1);
  localparam logic [LCW-1:0] LOCK_FULL = LCW'(LOCK_CNT);

  state_t         state, state_d;
  logic           div_q, div_qq;
  logic [CW-1:0]  per_cnt, high_cnt;
  logic [LCW-1:0] match_cnt;
  logic           match, per_sat, high_sat;
  logic           capture, timeout, per_err;

  assign rise_pulse = div_q & ~div_qq;
  assign fall_pulse = ~div_q & div_qq;
  assign match      = (exp_period != '0) && (per_cnt == exp_period);
  assign per_sat    = (per_cnt == MAX_CNT);
  assign high_sat   = (high_cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // A rise coinciding with counter saturation is a capture, never a timeout.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    timeout = 1'b0;
    per_err = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rise_pulse) state_d = ARMED;
        end
        ARMED: begin
          if (rise_pulse) begin
            capture = 1'b1;
            if (match && (match_cnt >= LOCK_LAST)) state_d = LOCKED;
          end else if (per_sat) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
        LOCKED: begin
          if (rise_pulse) begin
            capture = 1'b1;
            if (!match) begin
              per_err = 1'b1;
              state_d = ARMED;
            end
          end else if (per_sat) begin
            timeout = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= 1'b0;
      div_qq      <= 1'b0;
      per_cnt     <= '0;
      high_cnt    <= '0;
      match_cnt   <= '0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err_period  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      div_q       <= div_in;
      div_qq      <= div_q;
      meas_valid  <= capture;
      locked      <= (state_d == LOCKED);
      err_period  <= per_err | (err_period & ~clr_err);
      err_timeout <= timeout | (err_timeout & ~clr_err);
      if (capture) period <= per_cnt;
      if (en && (state != IDLE) && fall_pulse) high_time <= high_cnt;
      // Counters idle at zero; the arming rise starts them at 1.
      if (state_d == IDLE) begin
        per_cnt  <= '0;
        high_cnt <= '0;
      end else if (rise_pulse) begin
        per_cnt  <= CW'(1);
        high_cnt <= CW'(1);
      end else begin
        if (!per_sat) per_cnt <= per_cnt + CW'(1);
        if (div_q && !high_sat) high_cnt <= high_cnt + CW'(1);
      end
      if (state_d == IDLE) begin
        match_cnt <= '0;
      end else if (capture) begin
        if (!match)                       match_cnt <= '0;
        else if (match_cnt != LOCK_FULL)  match_cnt <= match_cnt + LCW'(1);
      end
    end
  end

endmodule
